// File: rtl/uop_sequencer.sv
// uop_sequencer: expands each decoded LC-3b instruction into one or two
// registered micro-ops, with valid/ready handshakes on the instruction side
// and the micro-op side. LDI/STI (indirect) and TRAP (link, then vector
// fetch) take two micro-ops. Every other opcode takes one.
module uop_sequencer #(
  parameter int ALUOP_W         = 4,
  parameter int TAG_W           = 4,
  parameter int ENABLE_INDIRECT = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3:0]         opcode,
  input  logic               imm_check,
  input  logic               jsr_check,
  input  logic               rshf_check,
  output logic               uop_valid,
  input  logic               uop_ready,
  output logic [ALUOP_W-1:0] uop_aluop,
  output logic [1:0]         uop_sr2_sel,
  output logic               uop_load_regfile,
  output logic               uop_load_cc,
  output logic               uop_mem_read,
  output logic               uop_mem_write,
  output logic [1:0]         uop_addr_sel,
  output logic [1:0]         uop_dest_sel,
  output logic               uop_byte,
  output logic               uop_first,
  output logic               uop_last,
  output logic               uop_illegal,
  output logic [TAG_W-1:0]   uop_tag
);

  // LC-3b opcodes
  localparam logic [3:0] OP_BR   = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_LDB  = 4'b0010;
  localparam logic [3:0] OP_STB  = 4'b0011;
  localparam logic [3:0] OP_JSR  = 4'b0100;
  localparam logic [3:0] OP_AND  = 4'b0101;
  localparam logic [3:0] OP_LDR  = 4'b0110;
  localparam logic [3:0] OP_STR  = 4'b0111;
  localparam logic [3:0] OP_NOT  = 4'b1001;
  localparam logic [3:0] OP_LDI  = 4'b1010;
  localparam logic [3:0] OP_STI  = 4'b1011;
  localparam logic [3:0] OP_JMP  = 4'b1100;
  localparam logic [3:0] OP_SHF  = 4'b1101;
  localparam logic [3:0] OP_LEA  = 4'b1110;
  localparam logic [3:0] OP_TRAP = 4'b1111;

  // lc3b_aluop encoding, zero-extended to ALUOP_W
  localparam logic [ALUOP_W-1:0] ALU_ADD = ALUOP_W'(0);
  localparam logic [ALUOP_W-1:0] ALU_AND = ALUOP_W'(1);
  localparam logic [ALUOP_W-1:0] ALU_NOT = ALUOP_W'(2);
  localparam logic [ALUOP_W-1:0] ALU_SLL = ALUOP_W'(4);
  localparam logic [ALUOP_W-1:0] ALU_SRL = ALUOP_W'(5);
  localparam logic [ALUOP_W-1:0] ALU_SRA = ALUOP_W'(6);

  // Operand / address / destination selects
  localparam logic [1:0] SR2_REG   = 2'b00;
  localparam logic [1:0] SR2_IMM5  = 2'b01;
  localparam logic [1:0] SR2_IMM4  = 2'b10;
  localparam logic [1:0] ADDR_BASE = 2'b00;
  localparam logic [1:0] ADDR_TEMP = 2'b01;
  localparam logic [1:0] ADDR_PC9  = 2'b10;
  localparam logic [1:0] ADDR_TVEC = 2'b11;
  localparam logic [1:0] DEST_DR   = 2'b00;
  localparam logic [1:0] DEST_R7   = 2'b01;
  localparam logic [1:0] DEST_TEMP = 2'b10;

  localparam bit INDIRECT = (ENABLE_INDIRECT != 0);

  typedef struct packed {
    logic [ALUOP_W-1:0] aluop;
    logic [1:0]         sr2_sel;
    logic               load_regfile;
    logic               load_cc;
    logic               mem_read;
    logic               mem_write;
    logic [1:0]         addr_sel;
    logic [1:0]         dest_sel;
    logic               byte_acc;
    logic               illegal;
  } uop_t;

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_SECOND = 1'b1
  } state_e;

  // First (or only) micro-op of an instruction.
  function automatic uop_t dec_first(input logic [3:0] op, input logic imm,
                                     input logic jsr, input logic rshf);
    uop_t u;
    u = '0;
    case (op)
      OP_ADD, OP_AND: begin
        u.aluop        = (op == OP_AND) ? ALU_AND : ALU_ADD;
        u.sr2_sel      = imm ? SR2_IMM5 : SR2_REG;
        u.load_regfile = 1'b1;
        u.load_cc      = 1'b1;
        u.dest_sel     = DEST_DR;
      end
      OP_NOT: begin
        u.aluop        = ALU_NOT;
        u.load_regfile = 1'b1;
        u.load_cc      = 1'b1;
      end
      OP_SHF: begin
        u.aluop        = !rshf ? ALU_SLL : (imm ? ALU_SRA : ALU_SRL);
        u.sr2_sel      = SR2_IMM4;
        u.load_regfile = 1'b1;
        u.load_cc      = 1'b1;
      end
      OP_LDR, OP_LDB: begin
        u.mem_read     = 1'b1;
        u.addr_sel     = ADDR_BASE;
        u.load_regfile = 1'b1;
        u.load_cc      = 1'b1;
        u.byte_acc     = (op == OP_LDB);
      end
      OP_STR, OP_STB: begin
        u.mem_write = 1'b1;
        u.addr_sel  = ADDR_BASE;
        u.byte_acc  = (op == OP_STB);
      end
      OP_LDI: begin
        u.mem_read = 1'b1;
        u.addr_sel = ADDR_BASE;
        if (INDIRECT) begin
          // pointer fetch lands in TEMP; the data load follows
          u.dest_sel = DEST_TEMP;
        end else begin
          u.load_regfile = 1'b1;
          u.load_cc      = 1'b1;
        end
      end
      OP_STI: begin
        u.addr_sel = ADDR_BASE;
        if (INDIRECT) begin
          u.mem_read = 1'b1;
          u.dest_sel = DEST_TEMP;
        end else begin
          u.mem_write = 1'b1;
        end
      end
      OP_LEA: begin
        u.addr_sel     = ADDR_PC9;
        u.load_regfile = 1'b1;
        u.load_cc      = 1'b1;
      end
      OP_BR:  u.addr_sel = ADDR_PC9;
      OP_JMP: u.addr_sel = ADDR_BASE;
      OP_JSR: begin
        u.dest_sel     = DEST_R7;
        u.load_regfile = 1'b1;
        u.addr_sel     = jsr ? ADDR_PC9 : ADDR_BASE;
      end
      OP_TRAP: begin
        u.load_regfile = 1'b1;
        u.dest_sel     = DEST_R7;
      end
      default: u.illegal = 1'b1;
    endcase
    return u;
  endfunction

  // Second micro-op of a two-access instruction.
  function automatic uop_t dec_second(input logic [3:0] op);
    uop_t u;
    u = '0;
    case (op)
      OP_LDI: begin
        u.mem_read     = 1'b1;
        u.addr_sel     = ADDR_TEMP;
        u.load_regfile = 1'b1;
        u.load_cc      = 1'b1;
        u.dest_sel     = DEST_DR;
      end
      OP_STI: begin
        u.mem_write = 1'b1;
        u.addr_sel  = ADDR_TEMP;
      end
      OP_TRAP: begin
        u.mem_read = 1'b1;
        u.addr_sel = ADDR_TVEC;
      end
      default: u = '0;
    endcase
    return u;
  endfunction

  function automatic logic is_two(input logic [3:0] op);
    return (op == OP_TRAP) || (INDIRECT && ((op == OP_LDI) || (op == OP_STI)));
  endfunction

  state_e             r_state;
  logic               r_valid;
  uop_t               r_uop;
  uop_t               r_pend;
  logic               r_first;
  logic               r_last;
  logic [TAG_W-1:0]   r_tag;
  logic [TAG_W-1:0]   r_tag_cnt;

  logic               w_accept;
  logic               w_two;
  uop_t               w_dec0;
  uop_t               w_dec1;

  assign in_ready = (r_state == S_IDLE) && (!r_valid || uop_ready);
  assign w_accept = in_valid && in_ready;
  assign w_two    = is_two(opcode);
  assign w_dec0   = dec_first(opcode, imm_check, jsr_check, rshf_check);
  assign w_dec1   = dec_second(opcode);

  // Sequencer: accepts instructions, presents uop0/uop1 and holds under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_valid   <= 1'b0;
      r_uop     <= '0;
      r_pend    <= '0;
      r_first   <= 1'b0;
      r_last    <= 1'b0;
      r_tag     <= '0;
      r_tag_cnt <= '0;
    end else if (flush) begin
      // drop presented/pending uops and any instruction offered now; tags keep counting
      r_valid <= 1'b0;
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_valid   <= 1'b1;
            r_uop     <= w_dec0;
            r_first   <= 1'b1;
            r_last    <= !w_two;
            r_tag     <= r_tag_cnt;
            r_tag_cnt <= r_tag_cnt + TAG_W'(1);
            if (w_two) begin
              r_pend  <= w_dec1;
              r_state <= S_SECOND;
            end
          end else if (uop_ready) begin
            r_valid <= 1'b0;
          end
        end
        S_SECOND: begin
          // uop0 is on the outputs; swap in uop1 once it is taken
          if (uop_ready) begin
            r_uop   <= r_pend;
            r_first <= 1'b0;
            r_last  <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign uop_valid        = r_valid;
  assign uop_aluop        = r_uop.aluop;
  assign uop_sr2_sel      = r_uop.sr2_sel;
  assign uop_load_regfile = r_uop.load_regfile;
  assign uop_load_cc      = r_uop.load_cc;
  assign uop_mem_read     = r_uop.mem_read;
  assign uop_mem_write    = r_uop.mem_write;
  assign uop_addr_sel     = r_uop.addr_sel;
  assign uop_dest_sel     = r_uop.dest_sel;
  assign uop_byte         = r_uop.byte_acc;
  assign uop_illegal      = r_uop.illegal;
  assign uop_first        = r_first;
  assign uop_last         = r_last;
  assign uop_tag          = r_tag;

endmodule

// File: tb/tb_uop_sequencer.sv
// Testbench for uop_sequencer: directed sequences plus randomized traffic,
// checked against an instruction-level queue model of the micro-op stream.
module tb_uop_sequencer;

  logic       clk;
  logic       rst_n;
  logic       flush;
  logic       in_valid;
  logic [3:0] opcode;
  logic       imm_check;
  logic       jsr_check;
  logic       rshf_check;
  logic       uop_ready;

  logic       in_ready, uop_valid;
  logic [3:0] uop_aluop;
  logic [1:0] uop_sr2_sel, uop_addr_sel, uop_dest_sel;
  logic       uop_load_regfile, uop_load_cc, uop_mem_read, uop_mem_write;
  logic       uop_byte, uop_first, uop_last, uop_illegal;
  logic [3:0] uop_tag;

  logic       ni_in_ready, ni_valid;
  logic [3:0] ni_aluop;
  logic [1:0] ni_sr2_sel, ni_addr_sel, ni_dest_sel;
  logic       ni_load_regfile, ni_load_cc, ni_mem_read, ni_mem_write;
  logic       ni_byte, ni_first, ni_last, ni_illegal;
  logic [3:0] ni_tag;

  uop_sequencer #(.ALUOP_W(4), .TAG_W(4), .ENABLE_INDIRECT(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .imm_check(imm_check), .jsr_check(jsr_check), .rshf_check(rshf_check),
    .uop_valid(uop_valid), .uop_ready(uop_ready), .uop_aluop(uop_aluop),
    .uop_sr2_sel(uop_sr2_sel), .uop_load_regfile(uop_load_regfile), .uop_load_cc(uop_load_cc),
    .uop_mem_read(uop_mem_read), .uop_mem_write(uop_mem_write), .uop_addr_sel(uop_addr_sel),
    .uop_dest_sel(uop_dest_sel), .uop_byte(uop_byte), .uop_first(uop_first),
    .uop_last(uop_last), .uop_illegal(uop_illegal), .uop_tag(uop_tag)
  );

  uop_sequencer #(.ALUOP_W(4), .TAG_W(4), .ENABLE_INDIRECT(0)) u_ni (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(ni_in_ready),
    .opcode(opcode), .imm_check(imm_check), .jsr_check(jsr_check), .rshf_check(rshf_check),
    .uop_valid(ni_valid), .uop_ready(uop_ready), .uop_aluop(ni_aluop),
    .uop_sr2_sel(ni_sr2_sel), .uop_load_regfile(ni_load_regfile), .uop_load_cc(ni_load_cc),
    .uop_mem_read(ni_mem_read), .uop_mem_write(ni_mem_write), .uop_addr_sel(ni_addr_sel),
    .uop_dest_sel(ni_dest_sel), .uop_byte(ni_byte), .uop_first(ni_first),
    .uop_last(ni_last), .uop_illegal(ni_illegal), .uop_tag(ni_tag)
  );

  // Expected field bundle: aluop, sr2, lr, lcc, mr, mw, addr, dest, byte, illegal
  typedef struct packed {
    logic [3:0] alu;
    logic [1:0] sr2;
    logic       lr, lcc, mr, mw;
    logic [1:0] addr, dest;
    logic       byt, ill;
  } fld_t;

  logic [21:0] w_obs, w_ni_obs;
  assign w_obs = {uop_aluop, uop_sr2_sel, uop_load_regfile, uop_load_cc, uop_mem_read,
                  uop_mem_write, uop_addr_sel, uop_dest_sel, uop_byte, uop_illegal,
                  uop_first, uop_last, uop_tag};
  assign w_ni_obs = {ni_aluop, ni_sr2_sel, ni_load_regfile, ni_load_cc, ni_mem_read,
                     ni_mem_write, ni_addr_sel, ni_dest_sel, ni_byte, ni_illegal,
                     ni_first, ni_last, ni_tag};

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: currently presented uop, pending uops of the instruction, next tag
  logic        m_valid;
  logic [21:0] m_cur;
  logic [21:0] pend_q[$];
  logic [3:0]  m_tag;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, obs, exp, $time);
    end
  endtask

  // Instruction-level reference: which micro-ops an opcode produces.
  function automatic void model_uops(input logic [3:0] op, input bit imm, input bit jsr,
                                     input bit rshf, input bit ind, output int n,
                                     output fld_t a, output fld_t b);
    a = '0; b = '0; n = 1;
    case (op)
      4'd1:  begin a.alu = 4'd0; a.sr2 = imm ? 2'd1 : 2'd0; a.lr = 1; a.lcc = 1; end
      4'd5:  begin a.alu = 4'd1; a.sr2 = imm ? 2'd1 : 2'd0; a.lr = 1; a.lcc = 1; end
      4'd9:  begin a.alu = 4'd2; a.lr = 1; a.lcc = 1; end
      4'd13: begin
        a.alu = rshf ? (imm ? 4'd6 : 4'd5) : 4'd4;
        a.sr2 = 2'd2; a.lr = 1; a.lcc = 1;
      end
      4'd6:  begin a.mr = 1; a.lr = 1; a.lcc = 1; end
      4'd2:  begin a.mr = 1; a.lr = 1; a.lcc = 1; a.byt = 1; end
      4'd7:  a.mw = 1;
      4'd3:  begin a.mw = 1; a.byt = 1; end
      4'd14: begin a.addr = 2'd2; a.lr = 1; a.lcc = 1; end
      4'd0:  a.addr = 2'd2;
      4'd12: a.addr = 2'd0;
      4'd4:  begin a.dest = 2'd1; a.lr = 1; a.addr = jsr ? 2'd2 : 2'd0; end
      4'd10: begin
        if (ind) begin
          n = 2; a.mr = 1; a.dest = 2'd2;
          b.mr = 1; b.addr = 2'd1; b.lr = 1; b.lcc = 1;
        end else begin
          a.mr = 1; a.lr = 1; a.lcc = 1;
        end
      end
      4'd11: begin
        if (ind) begin
          n = 2; a.mr = 1; a.dest = 2'd2;
          b.mw = 1; b.addr = 2'd1;
        end else begin
          a.mw = 1;
        end
      end
      4'd15: begin n = 2; a.lr = 1; a.dest = 2'd1; b.mr = 1; b.addr = 2'd3; end
      default: a.ill = 1;
    endcase
  endfunction

  // One clock: drive inputs, check in_ready, advance the model, check outputs after the edge.
  task automatic step(input bit v, input logic [3:0] op, input bit imm, input bit jsr,
                      input bit rshf, input bit rdy, input bit fl);
    bit   m_rdy;
    int   n;
    fld_t a, b;
    in_valid = v; opcode = op; imm_check = imm; jsr_check = jsr;
    rshf_check = rshf; uop_ready = rdy; flush = fl;
    #1;
    m_rdy = (pend_q.size() == 0) && (!m_valid || rdy);
    chk("in_ready", 32'(in_ready), 32'(m_rdy));
    if (fl) begin
      m_valid = 1'b0;
      pend_q.delete();
    end else if (v && m_rdy) begin
      model_uops(op, imm, jsr, rshf, 1'b1, n, a, b);
      m_cur   = {a, 1'b1, (n == 1), m_tag};
      m_valid = 1'b1;
      if (n == 2) pend_q.push_back({b, 1'b0, 1'b1, m_tag});
      m_tag = m_tag + 4'd1;
    end else if (m_valid && rdy) begin
      if (pend_q.size() > 0) m_cur = pend_q.pop_front();
      else m_valid = 1'b0;
    end
    @(posedge clk);
    #1;
    chk("uop_valid", 32'(uop_valid), 32'(m_valid));
    if (m_valid) chk("uop_fields", 32'(w_obs), 32'(m_cur));
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) step(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    int   n;
    fld_t a, b;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; opcode = 4'd0;
    imm_check = 1'b0; jsr_check = 1'b0; rshf_check = 1'b0; uop_ready = 1'b1;
    m_valid = 1'b0; m_cur = '0; m_tag = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 32'(uop_valid), 32'd0);
    chk("rst_fields", 32'(w_obs), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // ADD imm back-to-back, then ADD/AND register forms
    step(1, 4'b0001, 1, 0, 0, 1, 0);
    step(1, 4'b0001, 1, 0, 0, 1, 0);
    step(1, 4'b0101, 0, 0, 0, 1, 0);
    step(1, 4'b0001, 0, 0, 0, 1, 0);
    idle(2);

    // LDI with ready held high
    step(1, 4'b1010, 0, 0, 0, 1, 0);
    step(1, 4'b1001, 0, 0, 0, 1, 0);
    idle(2);

    // STI stalled three cycles, then drained
    step(1, 4'b1011, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 4'b0001, 1, 0, 0, 0, 0);
    idle(3);

    // TRAP, flush in the cycle uop0 is presented (with an ADD offered), then ADD
    step(1, 4'b1111, 0, 0, 0, 0, 0);
    step(1, 4'b0001, 1, 0, 0, 0, 1);
    step(1, 4'b0001, 1, 0, 0, 1, 0);
    idle(2);

    // Tag wrap over 17 NOTs, then the unknown opcode
    for (int i = 0; i < 17; i++) step(1, 4'b1001, 0, 0, 0, 1, 0);
    step(1, 4'b1000, 1, 1, 1, 1, 0);
    idle(2);

    // Every opcode with each flag combination
    for (int op = 0; op < 16; op++)
      for (int f = 0; f < 8; f++)
        step(1, 4'(op), f[0], f[1], f[2], 1, 0);
    idle(3);

    // Randomized traffic with backpressure and occasional flush
    for (int i = 0; i < 1500; i++)
      step($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0,
           $urandom_range(0, 15) == 0);
    idle(3);

    // Asynchronous reset while uop1 of an LDI is pending
    step(1, 4'b1010, 0, 0, 0, 0, 0);
    step(0, 4'b0000, 0, 0, 0, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(uop_valid), 32'd0);
    chk("async_rst_fields", 32'(w_obs), 32'd0);
    m_valid = 1'b0; pend_q.delete(); m_tag = 4'd0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Both instances fresh: STI then LDI, compared for the non-indirect build too
    step(1, 4'b1011, 0, 0, 0, 1, 0);
    model_uops(4'b1011, 0, 0, 0, 1'b0, n, a, b);
    chk("ni_sti_valid", 32'(ni_valid), 32'd1);
    chk("ni_sti", 32'(w_ni_obs), 32'({a, 1'b1, 1'b1, 4'd0}));
    step(1, 4'b1010, 0, 0, 0, 1, 0);
    model_uops(4'b1010, 0, 0, 0, 1'b0, n, a, b);
    chk("ni_ldi_valid", 32'(ni_valid), 32'd1);
    chk("ni_ldi", 32'(w_ni_obs), 32'({a, 1'b1, 1'b1, 4'd1}));
    idle(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uop_sequencer.md
Name: uop_sequencer

Overview:
- Parametrised successor to the single-cycle LC-3b control decode. Expands each decoded instruction into one or two registered micro-ops with valid/ready handshakes on both sides.
- Multi-access instructions are split into two micro-ops: LDI, STI (indirect) and TRAP (link, then vector fetch).
- Sits between the fetch/decode latch and the execute/memory stages. It replaces the combinational ROM's role in stall generation for multi-access ops.

Parameters:
- ALUOP_W, 4, width of the uop_aluop field; carries the lc3b_aluop encoding zero-extended.
- TAG_W, 4, width of the instruction sequence tag.
- ENABLE_INDIRECT, 1. When 1, LDI/STI expand to 2 uops. When 0, LDI/STI decode as single-uop LDR/STR (legacy behaviour).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- flush  in  1  synchronous pipeline flush
- in_valid  in  1  instruction presented
- in_ready  out  1  instruction accepted this cycle when in_valid && in_ready
- opcode  in  4  lc3b_opcode
- imm_check  in  1  IR[5]: immediate select / arithmetic right shift
- jsr_check  in  1  IR[11]: JSR (1) vs JSRR (0)
- rshf_check  in  1  IR[4]: right shift
- uop_valid  out  1  micro-op valid
- uop_ready  in  1  downstream accepts micro-op
- uop_aluop  out  ALUOP_W  ALU operation
- uop_sr2_sel  out  2  00 reg, 01 imm5, 10 imm4 shift amount
- uop_load_regfile  out  1  regfile write
- uop_load_cc  out  1  condition-code load
- uop_mem_read  out  1  memory read
- uop_mem_write  out  1  memory write
- uop_addr_sel  out  2  00 base+offset6, 01 TEMP register, 10 PC+offset9, 11 trap vector
- uop_dest_sel  out  2  00 DR, 01 R7, 10 TEMP
- uop_byte  out  1  byte access (LDB/STB)
- uop_first  out  1  first uop of instruction
- uop_last  out  1  last uop of instruction
- uop_illegal  out  1  unknown opcode
- uop_tag  out  TAG_W  instruction sequence number

Behaviour:
- Reset (rst_n low, asynchronous): uop_valid=0, all uop_* fields=0, state=IDLE, tag counter=0.
- States:
  - IDLE: no pending second uop.
  - SECOND: uop0 is presented, uop1 is pending.
- Output register rule: in_ready = (state==IDLE) && (!uop_valid || uop_ready). This is combinational, and the full-throughput path holds in IDLE.
- Accept (in_valid && in_ready):
  - Next cycle, uop_valid=1 and uop0 fields are presented (latency 1 cycle).
  - uop_first=1 and uop_tag=counter; counter increments, wrapping mod 2^TAG_W.
  - For a 2-uop instruction, uop_last=0 and state→SECOND; otherwise uop_last=1 and state stays IDLE.
- SECOND: on uop_valid && uop_ready, present uop1 next cycle with uop_first=0, uop_last=1 and the same tag; state→IDLE.
- No accept and uop_ready=1: uop_valid→0. If uop_ready=0, all outputs hold stable (no field change while valid && !ready).
- flush has priority over everything:
  - Next cycle uop_valid=0 and state=IDLE; the tag counter is not reset.
  - An instruction offered in the flush cycle is dropped.
- Single-uop decode:
  - ADD/AND: sr2_sel=00 if imm_check=0, else 01; load_regfile, load_cc, dest DR.
  - NOT: alu_not, load_regfile, load_cc.
  - SHF: alu_sll if rshf_check=0; otherwise alu_srl if imm_check=0, alu_sra if imm_check=1. sr2_sel=10, load_regfile, load_cc.
  - LDR/LDB: mem_read, addr 00, load_regfile, load_cc; uop_byte for LDB.
  - STR/STB: mem_write, addr 00; uop_byte for STB.
  - LEA: addr 10, load_regfile, load_cc.
  - BR: addr 10.
  - JMP: addr 00 with zero offset.
  - JSR/JSRR: dest R7, load_regfile; addr 10 if jsr_check=1, else 00.
  - Unknown (1000): all fields 0 with uop_illegal=1, uop_first=1, uop_last=1.
- Two-uop decode:
  - LDI: uop0 = mem_read addr 00, dest TEMP. uop1 = mem_read addr 01, load_regfile, load_cc, dest DR.
  - STI: uop0 = mem_read addr 00, dest TEMP. uop1 = mem_write addr 01.
  - TRAP: uop0 = load_regfile, dest R7. uop1 = mem_read addr 11.
- Reset mid-SECOND: uop1 is discarded immediately and uop_valid falls asynchronously.

Test Plan:
- ADD imm (opcode 0001, imm_check=1), uop_ready=1 → one cycle later uop_valid=1, aluop=alu_add, sr2_sel=01, first=last=1, tag=0; in_ready stays 1 for back-to-back instructions.
- LDI with ENABLE_INDIRECT=1, uop_ready=1 → cycle1: mem_read, addr 00, dest TEMP, first=1, last=0, in_ready=0. Cycle2: mem_read, addr 01, load_regfile, last=1, same tag. Cycle2 in_ready=1.
- STI with uop_ready=0 for 3 cycles → uop0 held stable, in_ready=0 throughout; after ready=1, uop1 has mem_write=1, addr 01. With ENABLE_INDIRECT=0 → single uop, mem_write, addr 00.
- TRAP then flush asserted in the cycle uop0 is presented → next cycle uop_valid=0, state IDLE, next ADD receives tag+1.
- 17 consecutive NOTs (TAG_W=4) → tags run 0..15 then 0; opcode 1000 → uop_illegal=1, all control fields 0.
- rst_n low while in SECOND → uop_valid=0 asynchronously; after release in_ready=1, tag=0.
